// File: rtl/audio_pkg.sv
// Shared constants and types for the audio DAC serializer and its BCLK divider.
package audio_pkg;
    localparam logic FMT_I2S       = 1'b0;
    localparam logic FMT_LJ        = 1'b1;
    localparam int   DEF_SAMPLE_W  = 24;
    localparam int   DEF_SLOT_W    = 32;
    localparam int   DEF_BCLK_HALF = 4;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;
endpackage

// File: rtl/audio_bclk_gen.sv
// BCLK divider: toggles bclk every BCLK_HALF sys_clk cycles and flags the
// cycle in which bclk goes 1->0 so the framer can update data in that same edge.
module audio_bclk_gen
    import audio_pkg::*;
#(
    parameter int BCLK_HALF = DEF_BCLK_HALF
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic fall
);
    localparam int             DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             run_q, run_d;
    logic             bclk_q, bclk_d;
    logic             tick_s;

    // The divider idles for the release cycle so the first rise lands BCLK_HALF cycles after it.
    always_comb begin
        run_d  = 1'b1;
        div_d  = div_q;
        bclk_d = bclk_q;
        tick_s = run_q && (div_q == DIV_LAST);
        if (!run_q) begin
            div_d = div_q;
        end else if (tick_s) begin
            div_d  = {DIV_W{1'b0}};
            bclk_d = ~bclk_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            div_q  <= {DIV_W{1'b0}};
            bclk_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk = bclk_q;
    assign fall = tick_s & bclk_q;
endmodule

// File: rtl/audio_dac_serializer.sv
// Stereo I2S / left-justified DAC serializer with a one-pair holding register,
// frame-synchronous mute/format latching and underrun signalling.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int SLOT_W    = DEF_SLOT_W,
    parameter int BCLK_HALF = DEF_BCLK_HALF
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                fmt,
    input  logic                mute,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                bclk,
    output logic                daclrc,
    output logic                dacdat,
    output logic                underrun
);
    localparam int             K_W    = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam logic [K_W-1:0] K_ZERO = {K_W{1'b0}};
    localparam logic [K_W-1:0] K_LAST = K_W'(SLOT_W - 1);

    logic                fall_s, load_s, xfer_s, lj_bit_s;
    logic [SAMPLE_W-1:0] cur_sample_s, lj_word_s;

    logic                hold_full_q, hold_full_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [SAMPLE_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic                fmt_q, fmt_d, mute_q, mute_d;
    logic [K_W-1:0]      k_q, k_d;
    slot_e               slot_q, slot_d;
    logic                prev_bit_q, prev_bit_d;
    logic                s_ready_q, s_ready_d;
    logic                daclrc_q, daclrc_d;
    logic                dacdat_q, dacdat_d;
    logic                underrun_q, underrun_d;

    audio_bclk_gen #(
        .BCLK_HALF(BCLK_HALF)
    ) u_bclk_gen (
        .clk  (sys_clk),
        .rst_n(sys_rst_n),
        .bclk (bclk),
        .fall (fall_s)
    );

    // Framing, hold handshake and serial bit selection.
    always_comb begin
        load_s      = fall_s && (slot_q == SLOT_LEFT) && (k_q == K_ZERO);
        xfer_s      = s_valid && s_ready_q;
        frame_l_d   = frame_l_q;
        frame_r_d   = frame_r_q;
        fmt_d       = fmt_q;
        mute_d      = mute_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        k_d         = k_q;
        slot_d      = slot_q;
        prev_bit_d  = prev_bit_q;
        daclrc_d    = daclrc_q;
        dacdat_d    = dacdat_q;

        if (load_s) begin
            frame_l_d = hold_full_q ? hold_l_q : {SAMPLE_W{1'b0}};
            frame_r_d = hold_full_q ? hold_r_q : {SAMPLE_W{1'b0}};
            fmt_d     = fmt;
            mute_d    = mute;
        end else begin
            fmt_d = fmt_q;
        end

        // A load looks at the hold as it was before this edge, so a same-cycle
        // transfer is kept for the following frame.
        if (load_s && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (xfer_s) begin
            hold_full_d = 1'b1;
            hold_l_d    = s_left;
            hold_r_d    = s_right;
        end else begin
            hold_full_d = hold_full_q;
        end

        s_ready_d  = ~hold_full_d;
        underrun_d = load_s && !hold_full_q;

        cur_sample_s = (slot_q == SLOT_LEFT) ? frame_l_d : frame_r_d;
        lj_word_s    = cur_sample_s << k_q;
        lj_bit_s     = lj_word_s[SAMPLE_W-1] & ~mute_d;

        // I2S replays the left-justified stream one BCLK late via prev_bit.
        if (fall_s) begin
            daclrc_d   = (slot_q == SLOT_RIGHT);
            dacdat_d   = (fmt_d == FMT_LJ) ? lj_bit_s : prev_bit_q;
            prev_bit_d = lj_bit_s;
            if (k_q == K_LAST) begin
                k_d    = K_ZERO;
                slot_d = (slot_q == SLOT_LEFT) ? SLOT_RIGHT : SLOT_LEFT;
            end else begin
                k_d = k_q + K_W'(1);
            end
        end else begin
            dacdat_d = dacdat_q;
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            hold_full_q <= 1'b0;
            hold_l_q    <= {SAMPLE_W{1'b0}};
            hold_r_q    <= {SAMPLE_W{1'b0}};
            frame_l_q   <= {SAMPLE_W{1'b0}};
            frame_r_q   <= {SAMPLE_W{1'b0}};
            fmt_q       <= FMT_LJ;
            mute_q      <= 1'b0;
            k_q         <= K_ZERO;
            slot_q      <= SLOT_LEFT;
            prev_bit_q  <= 1'b0;
            s_ready_q   <= 1'b0;
            daclrc_q    <= 1'b1;
            dacdat_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            frame_l_q   <= frame_l_d;
            frame_r_q   <= frame_r_d;
            fmt_q       <= fmt_d;
            mute_q      <= mute_d;
            k_q         <= k_d;
            slot_q      <= slot_d;
            prev_bit_q  <= prev_bit_d;
            s_ready_q   <= s_ready_d;
            daclrc_q    <= daclrc_d;
            dacdat_q    <= dacdat_d;
            underrun_q  <= underrun_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign daclrc   = daclrc_q;
    assign dacdat   = dacdat_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: expected frames are queued when pairs
// are offered and compared against the captured serial stream frame by frame.
module tb_audio_dac_serializer;
    localparam int SW = 24;
    localparam int SL = 32;
    localparam int BH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fmt = 1'b1;
    logic          mute = 1'b0;
    logic          s_valid = 1'b0;
    logic [SW-1:0] s_left = '0;
    logic [SW-1:0] s_right = '0;
    logic          s_ready, bclk, daclrc, dacdat, underrun;

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic          f;
        logic          m;
    } frame_t;

    frame_t sb[$];
    int     urun_log[$];
    int     checks = 0;
    int     errors = 0;
    int     edge_no = 0;
    int     dat_cnt = 0;
    int     urun_base = 0;
    int     dat_base = 0;
    logic   prev_lj = 1'b0;

    always #5 clk = ~clk;

    audio_dac_serializer #(
        .SAMPLE_W (SW),
        .SLOT_W   (SL),
        .BCLK_HALF(BH)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .fmt      (fmt),
        .mute     (mute),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_left   (s_left),
        .s_right  (s_right),
        .bclk     (bclk),
        .daclrc   (daclrc),
        .dacdat   (dacdat),
        .underrun (underrun)
    );

    // Edge 0 is the first edge that samples rst_n high; edge_no = last edge + 1.
    always @(posedge clk) begin
        if (!rst_n) edge_no <= 0;
        else        edge_no <= edge_no + 1;
    end

    always @(negedge clk) begin
        if (rst_n && underrun) urun_log.push_back(edge_no - 1);
        if (rst_n && dacdat) dat_cnt <= dat_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lj_stream(input frame_t f);
        logic [SL-1:0] ls, rs;
        ls = {f.l, {(SL-SW){1'b0}}};
        rs = {f.r, {(SL-SW){1'b0}}};
        return f.m ? 64'h0 : {ls, rs};
    endfunction

    function automatic logic [63:0] wire_stream(input frame_t f, input logic prev);
        logic [63:0] lj;
        lj = lj_stream(f);
        return f.f ? lj : {prev, lj[63:1]};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bclk"},     64'(bclk),     64'd0);
        chk({tag, "_daclrc"},   64'(daclrc),   64'd1);
        chk({tag, "_dacdat"},   64'(dacdat),   64'd0);
        chk({tag, "_s_ready"},  64'(s_ready),  64'd0);
        chk({tag, "_underrun"}, 64'(underrun), 64'd0);
    endtask

    task automatic release_rst();
        rst_n     = 1'b1;
        urun_base = urun_log.size();
        dat_base  = dat_cnt;
        sb.delete();
        prev_lj   = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        fmt     = 1'b1;
        mute    = 1'b0;
        repeat (n) @(negedge clk);
        release_rst();
    endtask

    task automatic wait_edge(input int n);
        for (int i = 0; i < n + 8 && edge_no < n; i++) @(negedge clk);
        if (edge_no < n) chk("wait_edge_timeout", 64'(edge_no), 64'(n));
    endtask

    task automatic chk_urun(input string tag, input int idx, input int exp);
        int obs;
        obs = (urun_log.size() > urun_base + idx) ? urun_log[urun_base + idx] : -1;
        chk(tag, 64'(obs), 64'(exp));
    endtask

    // Offers a pair (s_valid stays high) and returns at the negedge after the transfer.
    task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r, input logic m_at_load);
        logic rdy;
        bit   done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        sb.push_back('{l: l, r: r, f: fmt, m: m_at_load});
        for (int i = 0; i < 600 && !done; i++) begin
            rdy = s_ready;
            @(negedge clk);
            if (rdy) done = 1'b1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rise(output bit got);
        logic pb;
        got = 1'b0;
        pb  = bclk;
        for (int i = 0; i < 4 * BH + 4 && !got; i++) begin
            @(negedge clk);
            if (bclk && !pb) got = 1'b1;
            pb = bclk;
        end
    endtask

    task automatic check_frame(input string tag);
        logic [63:0] dat, lrc, exp;
        logic        pl;
        bit          ok, got;
        frame_t      f;
        ok  = 1'b0;
        pl  = daclrc;
        dat = '0;
        lrc = '0;
        for (int i = 0; i < 700 && !ok; i++) begin
            @(negedge clk);
            if (pl && !daclrc) ok = 1'b1;
            pl = daclrc;
        end
        for (int b = 0; b < 64 && ok; b++) begin
            wait_rise(got);
            if (!got) ok = 1'b0;
            dat[63-b] = dacdat;
            lrc[63-b] = daclrc;
        end
        if (!ok) begin
            chk({tag, "_capture_timeout"}, 64'd0, 64'd1);
        end else if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
        end else begin
            f   = sb.pop_front();
            exp = wire_stream(f, prev_lj);
            chk({tag, "_dat"}, dat, exp);
            chk({tag, "_lrc"}, lrc, 64'h0000_0000_FFFF_FFFF);
            exp     = lj_stream(f);
            prev_lj = exp[0];
        end
    endtask

    initial begin
        int early;

        // Reset values, then idle stream: underruns every frame, data stays 0.
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        release_rst();
        wait_edge(1);
        chk("rel_s_ready", 64'(s_ready), 64'd1);
        wait_edge(700);
        chk("idle_urun_cnt", 64'(urun_log.size() - urun_base), 64'd3);
        chk_urun("idle_urun0", 0, 4);
        chk_urun("idle_urun1", 1, 260);
        chk_urun("idle_urun2", 2, 516);
        chk("idle_dat_zero", 64'(dat_cnt - dat_base), 64'd0);

        // Left-justified single pair.
        do_reset(2);
        fmt = 1'b1;
        send_pair(24'hA5A5A5, 24'h800001, 1'b0);
        chk("lj_s_ready_drop", 64'(s_ready), 64'd0);
        s_valid = 1'b0;
        check_frame("lj");

        // I2S single pair.
        do_reset(2);
        fmt = 1'b0;
        send_pair(24'hA5A5A5, 24'h800001, 1'b0);
        s_valid = 1'b0;
        check_frame("i2s");

        // Three pairs streamed back to back with s_valid held high.
        do_reset(2);
        fmt = 1'b1;
        fork
            begin
                send_pair(24'h123456, 24'hFEDCBA, 1'b0);
                chk("stream_rdy0", 64'(s_ready), 64'd0);
                send_pair(24'h7FFFFF, 24'h000001, 1'b0);
                chk("stream_rdy1", 64'(s_ready), 64'd0);
                send_pair(24'hC3C3C3, 24'h3C3C3C, 1'b0);
                chk("stream_rdy2", 64'(s_ready), 64'd0);
                s_valid = 1'b0;
            end
            begin
                check_frame("stream0");
                check_frame("stream1");
                check_frame("stream2");
            end
        join
        early = 0;
        for (int i = urun_base; i < urun_log.size(); i++) if (urun_log[i] < 772) early++;
        chk("stream_no_urun", 64'(early), 64'd0);

        // Transfer in the same cycle as the first load.
        do_reset(2);
        fmt = 1'b1;
        sb.push_back('{l: '0, r: '0, f: 1'b1, m: 1'b0});
        fork
            begin
                wait_edge(4);
                send_pair(24'h5A5A5A, 24'h0F0F0F, 1'b0);
                chk("coinc_urun", 64'(underrun), 64'd1);
                chk("coinc_s_ready", 64'(s_ready), 64'd0);
                s_valid = 1'b0;
            end
            begin
                check_frame("coinc_zero");
                check_frame("coinc_pair");
            end
        join

        // Mute raised mid-frame, then a one-cycle reset mid-frame.
        do_reset(2);
        fmt = 1'b1;
        fork
            begin
                send_pair(24'h654321, 24'h89ABCD, 1'b0);
                send_pair(24'hFFFFFF, 24'hFFFFFF, 1'b1);
                s_valid = 1'b0;
                wait_edge(100);
                mute = 1'b1;
            end
            begin
                check_frame("mute_cur");
                check_frame("mute_next");
            end
        join
        chk("mute_consumed", 64'(s_ready), 64'd1);
        s_valid = 1'b1;
        s_left  = 24'h111111;
        s_right = 24'h222222;
        @(negedge clk);
        s_valid = 1'b0;
        chk("mid_hold_full", 64'(s_ready), 64'd0);
        wait_edge(600);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        release_rst();
        wait_edge(1);
        chk("midrst_s_ready", 64'(s_ready), 64'd1);
        wait_edge(6);
        chk_urun("midrst_hold_discarded", 0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_dac_serializer.md
AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001 Parameter: SAMPLE_W, default 24, bits per channel sample; SHALL satisfy 1 <= SAMPLE_W <= SLOT_W.
REQ-002 Parameter: SLOT_W, default 32, BCLK periods per channel slot; one frame SHALL be 2*SLOT_W BCLK periods.
REQ-003 Parameter: BCLK_HALF, default 4, sys_clk cycles per BCLK half-period; SHALL be >= 1.
REQ-004 sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-006 fmt  in  1  0 = I2S (one-BCLK data delay), 1 = left-justified.
REQ-007 mute  in  1  1 = next frame transmits zeros.
REQ-008 s_valid  in  1  sample pair offered.
REQ-009 s_ready  out  1  holding register empty.
REQ-010 s_left, s_right  in  SAMPLE_W each  two's-complement samples, MSB first on the wire.
REQ-011 bclk, daclrc, dacdat  out  1 each  codec serial clock, word select (0 = left), serial data.
REQ-012 underrun  out  1  one-cycle pulse when a frame starts with no sample held.

Function
REQ-013 Internal tick every BCLK_HALF sys_clk cycles; each tick SHALL toggle bclk (registered output).
REQ-014 All daclrc/dacdat updates SHALL occur in the same cycle bclk goes 1->0; they SHALL remain stable while bclk is high.
REQ-015 Slot bit counter k runs 0..SLOT_W-1 per falling edge, wraps, alternating left/right slot; daclrc = 0 throughout the left slot, 1 throughout the right slot, changing at k=0.
REQ-016 Left-justified stream: bit k < SAMPLE_W carries sample bit SAMPLE_W-1-k; bits k >= SAMPLE_W carry 0.
REQ-017 fmt=1: dacdat = LJ stream; fmt=0: dacdat = LJ stream delayed one BCLK period (MSB at k=1; k=0 carries the last bit of the previous slot).
REQ-018 Frame load at the falling edge with left slot, k=0: hold full -> frame registers <= hold, hold emptied; hold empty -> frame registers <= 0, underrun pulses for that one cycle.
REQ-019 mute and fmt SHALL be sampled only at frame load; mid-frame changes take effect next frame; a muted load still consumes the hold.
REQ-020 s_ready = hold empty; transfer when s_valid && s_ready; hold captures s_left/s_right.
REQ-021 Transfer and frame load in the same cycle: the load sees hold empty (underrun, zero frame); transferred pair stays in hold for the following frame.
REQ-022 s_valid without s_ready SHALL NOT alter hold; inputs are don't-care while s_valid = 0.
REQ-023 Sample latency: a pair transferred while hold is empty appears starting at the next frame load.

Reset
REQ-024 While sys_rst_n = 0: bclk=0, daclrc=1, dacdat=0, s_ready=0, underrun=0, hold empty, frame registers 0, divider/k/slot counters 0, latched fmt=1, latched mute=0.
REQ-025 First sys_clk edge with sys_rst_n=1: s_ready=1; first bclk rise BCLK_HALF cycles later; first falling edge (2*BCLK_HALF cycles after release) SHALL be a frame load.
REQ-026 Reset asserted mid-frame SHALL abort the frame and discard hold contents within one cycle.

Structure
REQ-027 Shared package audio_pkg SHALL hold FMT_I2S=0, FMT_LJ=1 and default SAMPLE_W/SLOT_W constants.
REQ-028 One sub-module audio_bclk_gen (divider producing tick and bclk, fall-strobe output) SHALL be instantiated; framing/shift logic stays in this module.
REQ-029 Counter widths SHALL be $clog2-derived from parameters; no fixed 8/32-bit counters.

Verification (SAMPLE_W=24, SLOT_W=32, BCLK_HALF=2; frame = 256 sys_clk cycles)
REQ-030 LJ: push L=0xA5A5A5, R=0x800001 before first load -> left slot bits 0..23 = 0xA5A5A5 MSB first, bits 24..31 = 0; right slot = 0x800001 then zeros; daclrc 0 then 1.
REQ-031 I2S: same data, fmt=0 -> every data bit shifted one BCLK later, left MSB at k=1, daclrc edges unchanged.
REQ-032 No s_valid after reset -> underrun pulses at cycle 4 and every 256 cycles after; dacdat constant 0.
REQ-033 Stream 3 pairs with s_valid held high -> s_ready drops after each transfer, rises the cycle after each load; no underrun; 3 frames carry pairs in order.
REQ-034 Transfer coinciding with load -> underrun pulses that cycle, zero frame; pair transmitted in the next frame.
REQ-035 mute=1 toggled mid-frame, then sys_rst_n low for 1 cycle mid-frame -> current frame unaffected, next frame zeros; after reset all outputs at REQ-024 values.
